// File: rtl/out_wrapper_fifo.sv
// Output stage of the FP multiplier: captures resDone products into a small
// show-ahead FIFO and hands them out under a valid/accept handshake.
module out_wrapper_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       resDone,
  input  logic [WIDTH-1:0]           resBus,
  input  logic                       outAccept,
  output logic                       outValid,
  output logic [WIDTH-1:0]           outBus,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic wr;
  logic rd;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign outValid = ~empty;
  assign outBus   = outValid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign rd = outValid & outAccept;
  assign wr = resDone & (~full | rd);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr) begin
      mem_d[wr_ptr_q] = resBus;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr && !rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd && !wr) begin
      count_d = count_q - CNT_W'(1);
    end
    if (resDone && !wr) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is qualified by count/pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
